iram_loader: RTL

Program loader for the instruction RAM: accepts a program as a stream of 4-bit nibbles over a valid/ready handshake, packs each pair into a byte, and writes the bytes into IRAM at consecutive addresses starting from a base address. It is the write side of the IRAM port that the fetch path reads through PC. While loading, it holds the processor in halt. When the programmed byte count has been written, it signals completion.

---
 rtl/iram_loader_if.sv | 24 ++
 rtl/iram_loader.sv | 94 +++++++++
 2 files changed

// File: rtl/iram_loader_if.sv
// Nibble stream into the loader and IRAM write port out of it.
// master = program source / IRAM side, slave = loader.
interface iram_loader_if #(
  parameter int ADDR_W = 16,
  parameter int NIB_W  = 4,
  parameter int DATA_W = 8
);
  logic              nib_valid;
  logic [NIB_W-1:0]  nib_data;
  logic              nib_ready;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_datain;

  modport master (
    output nib_valid, nib_data,
    input  nib_ready, mem_write_en, mem_addr, mem_datain
  );

  modport slave (
    input  nib_valid, nib_data,
    output nib_ready, mem_write_en, mem_addr, mem_datain
  );
endinterface

// File: rtl/iram_loader.sv
// IRAM program loader: packs high/low nibble pairs into bytes and writes them from base_addr.
// 3 cycles per byte minimum; nibbles are backpressured via nib_ready outside GET_HI/GET_LO.
module iram_loader #(
  parameter int ADDR_W = 16,
  parameter int NIB_W  = 4,
  parameter int DATA_W = 2 * NIB_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  iram_loader_if.slave      bus,
  output logic              busy,
  output logic              cpu_halt,
  output logic              done,
  output logic [ADDR_W-1:0] byte_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GET_HI = 3'd1;
  localparam logic [2:0] GET_LO = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_inc;
  logic [DATA_W-1:0] data_q;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            addr_q <= base_addr;
            len_q  <= length;
            cnt_q  <= '0;
            state  <= (length == '0) ? DONE : GET_HI;
          end
        end
        GET_HI: begin
          if (abort) begin
            state <= IDLE;
          end else if (bus.nib_valid) begin
            data_q[DATA_W-1:NIB_W] <= bus.nib_data;
            state                  <= GET_LO;
          end
        end
        GET_LO: begin
          if (abort) begin
            // Half-built byte must never reach IRAM.
            data_q <= '0;
            state  <= IDLE;
          end else if (bus.nib_valid) begin
            data_q[NIB_W-1:0] <= bus.nib_data;
            state             <= WRITE;
          end
        end
        WRITE: begin
          // The strobe is already visible this cycle, so the byte counts even on abort.
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_inc;
          if (abort)                  state <= IDLE;
          else if (cnt_inc == len_q)  state <= DONE;
          else                        state <= GET_HI;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.nib_ready    = (state == GET_HI) || (state == GET_LO);
  assign bus.mem_write_en = (state == WRITE);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_datain   = data_q;
  assign busy             = (state != IDLE);
  assign cpu_halt         = busy;
  assign done             = (state == DONE);
  assign byte_count       = cnt_q;

endmodule
